// File: rtl/matmul_sequencer_pkg.sv
// Shared types and helpers for the matmul sequencer and its result FIFO.
package matmul_sequencer_pkg;

    // Top-level control states.
    typedef enum logic [1:0] {
        StFlush,
        StIdle,
        StIssue,
        StDrain
    } state_e;

    // Bits needed to index n items; never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matmul_sequencer_if.sv
// Handshake bundle between the sequencer, the operand buffers, the engine and the consumer.
interface matmul_sequencer_if
    import matmul_sequencer_pkg::*;
#(
    parameter int unsigned DIM       = 8,
    parameter int unsigned RES_WIDTH = 67
);
    localparam int unsigned IDX_W = idx_width(DIM);

    logic                 go;
    logic                 ready;
    logic                 busy;
    logic                 done;
    logic                 opRead;
    logic [IDX_W-1:0]     rowAddr;
    logic [IDX_W-1:0]     colAddr;
    logic                 dpStart;
    logic                 dpReadEn;
    logic [RES_WIDTH-1:0] dpResult;
    logic                 resValid;
    logic                 resReady;
    logic [RES_WIDTH-1:0] resData;
    logic [IDX_W-1:0]     resRow;
    logic [IDX_W-1:0]     resCol;

    // Sequencer side.
    modport master (
        input  go, dpReadEn, dpResult, resReady,
        output ready, busy, done, opRead, rowAddr, colAddr, dpStart,
        output resValid, resData, resRow, resCol
    );

    // Environment side: job control, operand buffers, engine and consumer.
    modport slave (
        output go, dpReadEn, dpResult, resReady,
        input  ready, busy, done, opRead, rowAddr, colAddr, dpStart,
        input  resValid, resData, resRow, resCol
    );
endinterface

// File: rtl/matmul_sequencer_result_fifo.sv
// Synchronous result FIFO; the head entry is always presented on pop_data.
module matmul_sequencer_result_fifo
    import matmul_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 67,
    parameter int unsigned DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              push,
    input  logic [WIDTH-1:0]                  push_data,
    input  logic                              pop,
    output logic [WIDTH-1:0]                  pop_data,
    output logic [idx_width(DEPTH + 1)-1:0]   count,
    output logic                              full,
    output logic                              empty
);
    localparam int unsigned PTR_W = idx_width(DEPTH);
    localparam int unsigned CNT_W = idx_width(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    // Status flags and accepted operations; a push into a full FIFO only lands if a pop
    // frees the head slot in the same cycle.
    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        empty    = (count_q == '0);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        count    = count_q;
        pop_data = mem_q[rd_ptr_q];
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/matmul_sequencer.sv
// Walks all (row, col) pairs of a DIM x DIM product through one non-stallable dot-product
// engine, throttling issue with credits so every engine result has a FIFO slot waiting.
module matmul_sequencer
    import matmul_sequencer_pkg::*;
#(
    parameter int unsigned DIM        = 8,
    parameter int unsigned RES_WIDTH  = 67,
    parameter int unsigned DP_LATENCY = 13,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input logic                Clock,
    input logic                Resetn,
    matmul_sequencer_if.master bus
);
    localparam int unsigned IDX_W = idx_width(DIM);
    localparam int unsigned CNT_W = idx_width(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned FL_W  = idx_width(DP_LATENCY + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);

    state_e           state_q, state_d;
    logic [FL_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [IDX_W-1:0] row_q, row_d, col_q, col_d;
    logic [IDX_W-1:0] res_row_q, res_row_d, res_col_q, res_col_d;
    logic [CNT_W-1:0] in_flight_q, in_flight_d;
    logic             dp_start_q;

    logic             op_read;
    logic             credit_ok;
    logic             push;
    logic             pop;
    logic             ready;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [RES_WIDTH-1:0] res_data;

    matmul_sequencer_result_fifo #(
        .WIDTH (RES_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk       (Clock),
        .rst_n     (Resetn),
        .push      (push),
        .push_data (bus.dpResult),
        .pop       (pop),
        .pop_data  (res_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next-state, index counters, credit accounting and control outputs.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        row_d       = row_q;
        col_d       = col_q;
        res_row_d   = res_row_q;
        res_col_d   = res_col_q;
        op_read     = 1'b0;
        ready       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        // Engine results are only meaningful while a job is running; anything else is
        // leftover pipeline contents from before reset.
        push = bus.dpReadEn && ((state_q == StIssue) || (state_q == StDrain));
        pop  = !fifo_empty && bus.resReady;

        // Every issued operand pair owns a FIFO slot until its result is consumed.
        credit_ok = (SUM_W'(in_flight_q) + SUM_W'(fifo_count)) < SUM_W'(FIFO_DEPTH);

        // Result position follows consumer handshakes in issue order.
        if (pop) begin
            res_col_d = (res_col_q == LAST_IDX) ? '0 : res_col_q + 1'b1;
            if (res_col_q == LAST_IDX) begin
                res_row_d = (res_row_q == LAST_IDX) ? '0 : res_row_q + 1'b1;
            end
        end

        unique case (state_q)
            StFlush: begin
                if (flush_cnt_q == FL_W'(DP_LATENCY)) begin
                    state_d = StIdle;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            StIdle: begin
                ready = 1'b1;
                if (bus.go) begin
                    state_d   = StIssue;
                    row_d     = '0;
                    col_d     = '0;
                    res_row_d = '0;
                    res_col_d = '0;
                end
            end
            StIssue: begin
                busy    = 1'b1;
                op_read = credit_ok;
                if (op_read) begin
                    col_d = (col_q == LAST_IDX) ? '0 : col_q + 1'b1;
                    if (col_q == LAST_IDX) begin
                        row_d = (row_q == LAST_IDX) ? '0 : row_q + 1'b1;
                        if (row_q == LAST_IDX) begin
                            state_d = StDrain;
                        end
                    end
                end
            end
            StDrain: begin
                // Nothing in flight and nothing queued means the final handshake is done.
                if ((in_flight_q == '0) && (fifo_count == '0)) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end else begin
                    busy = 1'b1;
                end
            end
            default: state_d = StFlush;
        endcase

        in_flight_d = in_flight_q + CNT_W'(op_read) - CNT_W'(push);
        if (state_q == StIdle) begin
            in_flight_d = '0;
        end
    end

    // State and counter registers; reset discards any partial job.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= StFlush;
            flush_cnt_q <= '0;
            row_q       <= '0;
            col_q       <= '0;
            res_row_q   <= '0;
            res_col_q   <= '0;
            in_flight_q <= '0;
            dp_start_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            row_q       <= row_d;
            col_q       <= col_d;
            res_row_q   <= res_row_d;
            res_col_q   <= res_col_d;
            in_flight_q <= in_flight_d;
            dp_start_q  <= op_read;
        end
    end

    // Operand data arrives one cycle after the read, so the engine starts then.
    assign bus.ready    = ready;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.opRead   = op_read;
    assign bus.rowAddr  = row_q;
    assign bus.colAddr  = col_q;
    assign bus.dpStart  = dp_start_q;
    assign bus.resValid = !fifo_empty;
    assign bus.resData  = res_data;
    assign bus.resRow   = res_row_q;
    assign bus.resCol   = res_col_q;

    // Credits make this impossible; if it happens the engine result is lost.
    a_no_overflow: assert property (@(posedge Clock) disable iff (!Resetn)
        !(push && fifo_full && !pop))
        else $error("matmul_sequencer: engine result dropped, result fifo overflow");

endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Control block that drives one pipelined dot-product engine through a full DIM×DIM matrix multiply C = A·B. It walks row/column index pairs in row-major order and reads operand vectors from external A-row and B-column buffers. It pulses the engine's start input and collects engine results into a small result FIFO. Results go to a ready/valid consumer tagged with their (row, col) position. Credit-based issue throttling lets the consumer back-pressure without stalling the engine pipeline, which cannot stall.

## Interface
Parameters:
- DIM, 8, matrix dimension and engine vector length.
- RES_WIDTH, 67, engine result width.
- DP_LATENCY, 13, cycles from engine start to engine readEn; must equal DIM+5.
- FIFO_DEPTH, 16, result FIFO entries (≥1; full throughput needs ≥ DP_LATENCY+2).

Ports (IDX_W = clog2(DIM), minimum 1):
- Clock  in  1  single clock, rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- go  in  1  start a job; sampled only when ready is high.
- ready  out  1  can accept go (IDLE and flush complete).
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse, job complete.
- opRead  out  1  operand buffer read strobe; buffer data is valid next cycle.
- rowAddr  out  IDX_W  A-row index for the read.
- colAddr  out  IDX_W  B-column index for the read.
- dpStart  out  1  engine start; opRead delayed one cycle.
- dpReadEn  in  1  engine result-valid.
- dpResult  in  RES_WIDTH  engine result.
- resValid  out  1  result available.
- resReady  in  1  consumer accepts.
- resData  out  RES_WIDTH  result value.
- resRow  out  IDX_W  C row of resData.
- resCol  out  IDX_W  C column of resData.

## Operation
- States: FLUSH, IDLE, ISSUE, DRAIN.
- FLUSH: entered on reset. The engine has no reset, so a counter waits DP_LATENCY+1 cycles and dpReadEn is ignored. Then go to IDLE.
- IDLE: ready=1. go → ISSUE, clearing the issue index, result index and inFlight counter.
- ISSUE: opRead=1 when inFlight + fifoCount < FIFO_DEPTH, otherwise hold.
  - Issue index (row, col) advances row-major: col wraps DIM-1→0 and row increments.
  - After index (DIM-1, DIM-1) issues → DRAIN.
- inFlight: +1 on opRead, −1 on accepted dpReadEn; both in the same cycle leaves it unchanged.
- DRAIN: wait until inFlight=0, fifoCount=0 and the last handshake occurs. Then pulse done and go to IDLE.
- Results return in issue order. resRow/resCol come from a row-major result counter that advances on each resValid&resReady; no tags travel with the data.
- dpReadEn with a full FIFO cannot occur by construction. Flag it with a simulation assertion; the write is dropped.
- dpReadEn in IDLE or FLUSH is ignored.
- go while not ready is ignored.
- FIFO: push and pop in the same cycle are allowed when full or when empty-with-bypass disabled. Push data is visible on resData the cycle after the write.
- Reset mid-job: all state clears immediately and the partial job is lost. In-flight engine results are swallowed by FLUSH.

## Timing
- Reset values: ready=0, busy=0, done=0, opRead=0, dpStart=0, resValid=0, rowAddr=colAddr=resRow=resCol=0, resData=0.
- go sampled at edge t → busy and first opRead at t+1.
- dpStart at t+2; first dpReadEn at t+2+DP_LATENCY; first resValid one cycle later.
- Unthrottled job (resReady=1, FIFO_DEPTH ≥ DP_LATENCY+2): DIM² consecutive opReads. The last resValid falls DIM²−1 cycles after the first. done is asserted the cycle after the final handshake, and busy falls with done.
- ready rises the cycle after done.

## Structure
- Shared include (alongside clogb2.v): CLOG2 macro, state encodings, IDX_W derivation.
- One sub-module: result_fifo, a synchronous FIFO with RES_WIDTH data, count output and async active-low reset.
- The remaining FSM, counters and credit logic sit in the top module.

## Test plan
- Reset, then go held high from cycle 0: ready rises at cycle DP_LATENCY+2 and go is accepted only then. A stray dpReadEn at cycle 5 produces no resValid.
- DIM=8 identity A, B[i][j]=i·8+j, resReady=1: 64 results with resRow/resCol in row-major order, values equal to B. done comes 1 cycle after the 64th handshake, about 80 cycles after go.
- FIFO_DEPTH=4, resReady=0 for 100 cycles: exactly 4 opReads, then none. fifoCount=4, no overflow assertion. Releasing resReady resumes issue with no lost or duplicated result.
- Random resReady at 30% duty: all 64 (row, col) pairs appear exactly once, in order, with data matching a reference model.
- Resetn pulsed low at result 20: outputs return to reset values. The next job after FLUSH produces 64 correct results with no stale data.
- go pulsed during ISSUE: ignored, and the job count stays 1.
